// File: rtl/sram_seq_pkg.sv
// sram_seq_pkg: shared state type, constants and helpers for the SRAM ownership sequencer
// Contents: sram_seq_state_type, WDOG_CYCLES_DEF (default watchdog length),
// GAP_CYCLES (length of the bus hand-over gap), ch_ok (channel index range check).
package sram_seq_pkg;
  typedef enum logic [1:0] {S_SEQ_IDLE, S_SEQ_RUN, S_SEQ_GAP} sram_seq_state_type;
  localparam int WDOG_CYCLES_DEF = 50000000;
  localparam int GAP_CYCLES = 1;
  function automatic logic ch_ok(input int unsigned ch, input int unsigned n);
    return ch < n;
  endfunction
endpackage

// File: rtl/sram_client_mux.sv
// sram_client_mux: NUM_CH-way mux of client address, write data and write enable onto the SRAM port
// Ports: sel (owner index), en (low drives the bus to its reset values),
// force_idle (holds we_n high), ch_addr/ch_wdata/ch_we_n (flattened client buses),
// addr/wdata/we_n (to SRAM controller).
module sram_client_mux #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int CH_W = $clog2(NUM_CH)
) (
  input  logic [CH_W-1:0]          sel,
  input  logic                     en,
  input  logic                     force_idle,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [NUM_CH-1:0]        ch_we_n,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        wdata,
  output logic                     we_n
);
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic w;
  always_comb begin
    a = '0;
    d = '0;
    w = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (sel == CH_W'(i)) begin
        a = ch_addr[i*ADDR_W +: ADDR_W];
        d = ch_wdata[i*DATA_W +: DATA_W];
        w = ch_we_n[i];
      end
    addr = en ? a : '0;
    wdata = en ? d : '0;
    we_n = !en || force_idle || w;
  end
endmodule

// File: rtl/sram_seq_arbiter.sv
// sram_seq_arbiter: hands the single SRAM port to client units in a programmable slot order
// Ports: CLOCK_50_I/resetn (async active-low), go (start a run), stage_ch_i (slot channels,
// slot 0 in LSBs), idle_ch_i (owner between runs), ch_start_o/ch_finish_i (level start,
// pulse finish), ch_addr_i/ch_wdata_i/ch_we_n_i (client buses), SRAM_* (muxed bus),
// active_ch_o (owner), busy_o, done_o (run-complete pulse), timeout_o (sticky abort).
// Build option: define SRAM_SEQ_WATCHDOG_EN to abort a stage after WDOG_CYCLES in RUN.
module sram_seq_arbiter import sram_seq_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
  parameter int CH_W = $clog2(NUM_CH)
) (
  input  logic                         CLOCK_50_I,
  input  logic                         resetn,
  input  logic                         go,
  input  logic [NUM_STAGES*CH_W-1:0]   stage_ch_i,
  input  logic [CH_W-1:0]              idle_ch_i,
  output logic [NUM_CH-1:0]            ch_start_o,
  input  logic [NUM_CH-1:0]            ch_finish_i,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]     ch_wdata_i,
  input  logic [NUM_CH-1:0]            ch_we_n_i,
  output logic [ADDR_W-1:0]            SRAM_address_o,
  output logic [DATA_W-1:0]            SRAM_write_data_o,
  output logic                         SRAM_we_n_o,
  output logic [CH_W-1:0]              active_ch_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         timeout_o
);
  localparam int SW = $clog2(NUM_STAGES + 1);
  sram_seq_state_type state;
  logic [CH_W-1:0] owner;
  logic [NUM_STAGES*CH_W-1:0] pend;
  logic [SW-1:0] stage;
  logic bus_en;
  logic [CH_W-1:0] first_ch, next_ch;
  assign first_ch = stage_ch_i[CH_W-1:0];
  assign next_ch = pend[CH_W-1:0];
  assign active_ch_o = owner;
  assign busy_o = state != S_SEQ_IDLE;
`ifdef SRAM_SEQ_WATCHDOG_EN
  logic [25:0] wdog;
`else
  assign timeout_o = 1'b0;
`endif
  // pend holds the slots still to come, so the next channel is always in its LSBs.
  // An out-of-range slot keeps the previous owner and costs only a GAP cycle.
  always_ff @(posedge CLOCK_50_I or negedge resetn)
    if (!resetn) begin
      state <= S_SEQ_IDLE;
      owner <= '0;
      pend <= '0;
      stage <= '0;
      bus_en <= 1'b0;
      ch_start_o <= '0;
      done_o <= 1'b0;
`ifdef SRAM_SEQ_WATCHDOG_EN
      wdog <= '0;
      timeout_o <= 1'b0;
`endif
    end else begin
      bus_en <= 1'b1;
      done_o <= 1'b0;
`ifdef SRAM_SEQ_WATCHDOG_EN
      wdog <= state == S_SEQ_RUN ? wdog + 1'b1 : '0;
`endif
      case (state)
        S_SEQ_IDLE: begin
          owner <= ch_ok(32'(idle_ch_i), NUM_CH) ? idle_ch_i : '0;
          if (go) begin
            pend <= stage_ch_i >> CH_W;
            stage <= '0;
`ifdef SRAM_SEQ_WATCHDOG_EN
            timeout_o <= 1'b0;
`endif
            if (ch_ok(32'(first_ch), NUM_CH)) begin
              owner <= first_ch;
              ch_start_o <= NUM_CH'(1) << first_ch;
              state <= S_SEQ_RUN;
            end else
              state <= S_SEQ_GAP;
          end
        end
        S_SEQ_RUN:
          if (|(ch_finish_i & ch_start_o)) begin
            ch_start_o <= '0;
            state <= S_SEQ_GAP;
          end
`ifdef SRAM_SEQ_WATCHDOG_EN
          else if (wdog == 26'(WDOG_CYCLES - 1)) begin
            ch_start_o <= '0;
            timeout_o <= 1'b1;
            state <= S_SEQ_IDLE;
          end
`endif
        S_SEQ_GAP:
          if (stage == SW'(NUM_STAGES - 1)) begin
            done_o <= 1'b1;
            state <= S_SEQ_IDLE;
          end else begin
            stage <= stage + 1'b1;
            pend <= pend >> CH_W;
            if (ch_ok(32'(next_ch), NUM_CH)) begin
              owner <= next_ch;
              ch_start_o <= NUM_CH'(1) << next_ch;
              state <= S_SEQ_RUN;
            end else
              state <= S_SEQ_GAP;
          end
        default: state <= S_SEQ_IDLE;
      endcase
    end
  sram_client_mux #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CH_W(CH_W)) u_mux (
    .sel(owner),
    .en(bus_en),
    .force_idle(state == S_SEQ_GAP),
    .ch_addr(ch_addr_i),
    .ch_wdata(ch_wdata_i),
    .ch_we_n(ch_we_n_i),
    .addr(SRAM_address_o),
    .wdata(SRAM_write_data_o),
    .we_n(SRAM_we_n_o)
  );
endmodule
